// File: rtl/pe_col_drain.sv
// Drain sequencer for one systolic column: MM partial-sum drain and FP result packing into an output FIFO.
// Optional performance counters are enabled by defining PE_COL_DRAIN_PERF_CNT_EN.
module pe_col_drain #(
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CAP_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_sel_in,
  input  logic        drain_start,
  input  logic [47:0] bottom_in,
  input  logic        fp_valid_in,
  input  logic        fp_last_in,
  output logic        fp_ready_out,
  output logic        sys_buf_en_out,
  output logic        psu_clr_out,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        ovf_sticky,
  output logic [2:0]  o_dbg_state
`ifdef PE_COL_DRAIN_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] drain_cnt
`endif
);

  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TAIL_CYC = (CAP_LAT < 1) ? 1 : CAP_LAT;
  localparam int TW       = (TAIL_CYC > 1) ? $clog2(TAIL_CYC) : 1;

  // Output stream handshake: a word transfers on every cycle where
  // out_valid & out_ready; head data/last hold while out_valid & ~out_ready.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DRAIN = 3'd2,
    S_TAIL  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [RW-1:0]   r_row_cnt;
  logic [RW-1:0]   r_cap_cnt;
  logic [TW-1:0]   r_tail_cnt;
  logic            w_strobe;

  logic [32:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_full, w_space_ok, w_pop, w_wr;
  logic            w_push, w_push_last;
  logic [31:0]     w_push_data;
  logic [32:0]     w_head;

  logic            r_half_vld;
  logic [15:0]     r_half;
  logic            w_fp_acc, w_fp_drop;
  logic            w_unused;

  assign w_unused   = ^{bottom_in[47:32], mode_sel_in[0]};

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_space_ok = (r_count <= CW'(FIFO_DEPTH - ROWS));
  assign w_pop      = out_valid & out_ready;
  assign w_wr       = w_push & (~w_full | w_pop);

  assign sys_buf_en_out = (r_state == S_DRAIN);
  assign psu_clr_out    = (r_state == S_CLEAR);
  assign busy           = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

  assign fp_ready_out = (r_state == S_IDLE) & ~w_full;
  assign w_fp_acc     = mode_sel_in[1] & fp_valid_in & fp_ready_out;
  assign w_fp_drop    = mode_sel_in[1] & fp_valid_in & ~fp_ready_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (drain_start && !mode_sel_in[1]) w_next = w_space_ok ? S_DRAIN : S_WAIT;
      S_WAIT:  if (w_space_ok) w_next = S_DRAIN;
      S_DRAIN: if (r_row_cnt == RW'(ROWS - 1)) w_next = S_TAIL;
      S_TAIL:  if (r_tail_cnt == TW'(TAIL_CYC - 1)) w_next = S_CLEAR;
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt  <= '0;
      r_tail_cnt <= '0;
    end else begin
      r_row_cnt  <= (r_state == S_DRAIN) ? r_row_cnt + RW'(1) : '0;
      r_tail_cnt <= (r_state == S_TAIL) ? r_tail_cnt + TW'(1) : '0;
    end
  end

  // Capture strobe: the shift enable delayed by the PE output latency.
  generate
    if (CAP_LAT == 0) begin : g_nolat
      assign w_strobe = sys_buf_en_out;
    end else begin : g_lat
      logic r_dly [CAP_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < CAP_LAT; i++) r_dly[i] <= 1'b0;
        end else begin
          r_dly[0] <= sys_buf_en_out;
          for (int i = 1; i < CAP_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_strobe = r_dly[CAP_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_cnt <= '0;
    end else if (w_strobe) begin
      r_cap_cnt <= (r_cap_cnt == RW'(ROWS - 1)) ? '0 : r_cap_cnt + RW'(1);
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_push_last = 1'b0;
    if (w_strobe) begin
      w_push      = 1'b1;
      w_push_data = bottom_in[31:0];
      w_push_last = (r_cap_cnt == RW'(ROWS - 1));
    end else if (w_fp_acc) begin
      if (r_half_vld) begin
        w_push      = 1'b1;
        w_push_data = {bottom_in[15:0], r_half};
        w_push_last = fp_last_in;
      end else if (fp_last_in) begin
        w_push      = 1'b1;
        w_push_data = {16'h0000, bottom_in[15:0]};
        w_push_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half_vld <= 1'b0;
      r_half     <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (w_fp_acc) begin
        if (r_half_vld) begin
          r_half_vld <= 1'b0;
        end else if (!fp_last_in) begin
          r_half_vld <= 1'b1;
          r_half     <= bottom_in[15:0];
        end
      end
      if (w_fp_drop) ovf_sticky <= 1'b1;
    end
  end

  // FIFO storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign out_valid = (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign out_data  = out_valid ? w_head[31:0] : '0;
  assign out_last  = out_valid ? w_head[32] : 1'b0;

`ifdef PE_COL_DRAIN_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (r_state == S_CLEAR) drain_cnt <= drain_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_col_drain.sv
// Self-checking bench for pe_col_drain: FSM timing checks inline, output words checked against a queue.
module tb_pe_col_drain;
  localparam int ROWS = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int CAP_LAT = 1;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_sel_in = 2'b00;
  logic        drain_start = 1'b0;
  logic [47:0] bottom_in = '0;
  logic        fp_valid_in = 1'b0;
  logic        fp_last_in = 1'b0;
  logic        fp_ready_out, sys_buf_en_out, psu_clr_out, busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        ovf_sticky;
  logic [2:0]  o_dbg_state;
`ifdef PE_COL_DRAIN_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] drain_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];

  pe_col_drain #(.ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH), .CAP_LAT(CAP_LAT)) dut (
    .clk(clk), .rst(rst), .mode_sel_in(mode_sel_in), .drain_start(drain_start),
    .bottom_in(bottom_in), .fp_valid_in(fp_valid_in), .fp_last_in(fp_last_in),
    .fp_ready_out(fp_ready_out), .sys_buf_en_out(sys_buf_en_out), .psu_clr_out(psu_clr_out),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ovf_sticky(ovf_sticky), .o_dbg_state(o_dbg_state)
`ifdef PE_COL_DRAIN_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .drain_cnt(drain_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted output word is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL out_word_unexpected got last=%0b data=%h, required none", out_last, out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          tests_failed++;
          $display("FAIL out_word got last=%0b data=%h, required last=%0b data=%h",
                   out_last, out_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drain_out got pending=%0d out_valid=%0b, required pending=0 out_valid=0",
               name, exp_q.size(), out_valid);
    end
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({sys_buf_en_out, psu_clr_out, busy, out_valid, out_last, ovf_sticky} !== 6'b0 ||
        out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs got en=%0b clr=%0b busy=%0b v=%0b last=%0b ovf=%0b data=%h, required all 0",
               sys_buf_en_out, psu_clr_out, busy, out_valid, out_last, ovf_sticky, out_data);
    end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fp_ready_out !== 1'b1 || o_dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_release got fp_ready=%0b state=%0d, required 1 and %0d",
               fp_ready_out, o_dbg_state, ST_IDLE);
    end
    tick();
  endtask

  // One MM drain from an empty FIFO; optionally pokes drain_start while busy.
  task automatic test_drain_basic(input bit poke_busy);
    logic exp_en, exp_clr, exp_busy;
    mode_sel_in = 2'b00;
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      drain_start = (c == 0) || (poke_busy && c == 5);
      bottom_in = {16'($urandom_range(0, 16'hFFFF)), 32'($urandom())};
      if (c == 2) bottom_in[31:0] = 32'hAAAA_0001;
      if (c >= 2 && c <= 9) exp_q.push_back({(c == 9), bottom_in[31:0]});
      exp_en   = (c >= 1 && c <= 8);
      exp_clr  = (c == 10);
      exp_busy = (c >= 1 && c <= 10);
      @(negedge clk);
      tests_run++;
      if (sys_buf_en_out !== exp_en || psu_clr_out !== exp_clr || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL drain_cycle%0d got en=%0b clr=%0b busy=%0b, required en=%0b clr=%0b busy=%0b",
                 c, sys_buf_en_out, psu_clr_out, busy, exp_en, exp_clr, exp_busy);
      end
      tick();
    end
    drain_start = 1'b0;
    bottom_in = '0;
    wait_empty("drain_basic");
  endtask

  task automatic test_fp_pack;
    logic [15:0] vals [3];
    vals[0] = 16'h3F80; vals[1] = 16'h4000; vals[2] = 16'hC040;
    mode_sel_in = 2'b10;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drain_start = (c == 0);
      fp_valid_in = 1'b1;
      fp_last_in = (c == 2);
      bottom_in = {32'h0, vals[c]};
      if (c == 1) exp_q.push_back({1'b0, 32'h4000_3F80});
      if (c == 2) exp_q.push_back({1'b1, 32'h0000_C040});
      @(negedge clk);
      tests_run++;
      if (fp_ready_out !== 1'b1 || (c > 0 && busy !== 1'b0)) begin
        tests_failed++;
        $display("FAIL fp_pack_ready%0d got fp_ready=%0b busy=%0b, required 1 and 0", c, fp_ready_out, busy);
      end
      tick();
    end
    drain_start = 1'b0;
    fp_valid_in = 1'b0;
    fp_last_in = 1'b0;
    wait_empty("fp_pack");
  endtask

  // Loads n FP results in pairs with out_ready low; last flag on the final one.
  task automatic fp_fill(input int n);
    logic [15:0] lo;
    mode_sel_in = 2'b10;
    out_ready = 1'b0;
    lo = '0;
    for (int i = 0; i < n; i++) begin
      fp_valid_in = 1'b1;
      fp_last_in = (i == n - 1);
      bottom_in = {32'($urandom()), 16'($urandom_range(0, 16'hFFFF))};
      if (i % 2 == 0) lo = bottom_in[15:0];
      else exp_q.push_back({(i == n - 1), bottom_in[15:0], lo});
      tick();
    end
    fp_valid_in = 1'b0;
    fp_last_in = 1'b0;
    bottom_in = '0;
  endtask

  task automatic test_wait_space;
    logic exp_en, exp_clr, exp_busy;
    fp_fill(20);
    mode_sel_in = 2'b00;
    for (int c = 0; c <= 17; c++) begin
      drain_start = (c == 0);
      out_ready = (c == 4 || c == 5);
      bottom_in = {16'h0, 32'($urandom())};
      if (c >= 8 && c <= 15) exp_q.push_back({(c == 15), bottom_in[31:0]});
      exp_en   = (c >= 7 && c <= 14);
      exp_clr  = (c == 16);
      exp_busy = (c >= 1 && c <= 16);
      @(negedge clk);
      tests_run++;
      if (sys_buf_en_out !== exp_en || psu_clr_out !== exp_clr || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL wait_space_cycle%0d got en=%0b clr=%0b busy=%0b, required en=%0b clr=%0b busy=%0b",
                 c, sys_buf_en_out, psu_clr_out, busy, exp_en, exp_clr, exp_busy);
      end
      if (c >= 1 && c <= 6) begin
        tests_run++;
        if (o_dbg_state !== ST_WAIT) begin
          tests_failed++;
          $display("FAIL wait_space_state%0d got %0d, required %0d", c, o_dbg_state, ST_WAIT);
        end
      end
      tick();
    end
    drain_start = 1'b0;
    bottom_in = '0;
    out_ready = 1'b1;
    wait_empty("wait_space");
  endtask

  task automatic test_fp_overflow;
    fp_fill(2 * FIFO_DEPTH);
    fp_valid_in = 1'b1;
    bottom_in = {32'h0, 16'hBEEF};
    @(negedge clk);
    tests_run++;
    if (fp_ready_out !== 1'b0 || ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_full got fp_ready=%0b ovf=%0b, required 0 and 0", fp_ready_out, ovf_sticky);
    end
    tick();
    fp_valid_in = 1'b0;
    bottom_in = '0;
    @(negedge clk);
    tests_run++;
    if (ovf_sticky !== 1'b1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set got ovf=%0b out_valid=%0b, required 1 and 1", ovf_sticky, out_valid);
    end
    tick();
    out_ready = 1'b1;
    wait_empty("fp_overflow");
    tests_run++;
    if (ovf_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky_hold got %0b, required 1", ovf_sticky);
    end
  endtask

  task automatic test_reset_mid_drain;
    mode_sel_in = 2'b00;
    out_ready = 1'b0;
    bottom_in = 48'h0000_1234_5678;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (sys_buf_en_out !== 1'b1 || o_dbg_state !== ST_DRAIN) begin
      tests_failed++;
      $display("FAIL mid_drain_pre got en=%0b state=%0d, required 1 and %0d", sys_buf_en_out, o_dbg_state, ST_DRAIN);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (sys_buf_en_out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_drain_reset got en=%0b v=%0b busy=%0b ovf=%0b, required all 0",
               sys_buf_en_out, out_valid, busy, ovf_sticky);
    end
    tick();
    rst = 1'b0;
    bottom_in = '0;
    out_ready = 1'b1;
    tick();
    tick();
    test_drain_basic(1'b0);
`ifdef PE_COL_DRAIN_PERF_CNT_EN
    tests_run++;
    if (drain_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL perf_drain_cnt got %0d, required 1", drain_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_drain_basic(1'b0);
    test_drain_basic(1'b1);
    test_fp_pack();
    test_wait_space();
    test_fp_overflow();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running, required finish");
    $fatal(1, "timeout");
  end

endmodule
